acl2_axil_slave_regs: RTL and testbench

//  AXI4-Lite responder (slave) for the ACL2 PMOD IP register bank; the target end of the S00_AXI master link.

---
 rtl/acl2_axil_pkg.sv | 12 +
 rtl/acl2_axil_rd_chan.sv | 82 ++++++++
 rtl/acl2_axil_slave_regs.sv | 171 +++++++++++++++++
 tb/tb_acl2_axil_slave_regs.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acl2_axil_pkg.sv
// Shared AXI4-Lite response codes, address constants and FSM state types
// for the ACL2 register-bank slave.
package acl2_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int         ADDR_LSB    = 2;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

endpackage

// File: rtl/acl2_axil_rd_chan.sv
// AR/R channel of the ACL2 register slave: read FSM and register read mux.
// Optional macro ACL2_AXIL_SLVERR_EN: out-of-range reads return SLVERR and zero data.
module acl2_axil_rd_chan
    import acl2_axil_pkg::*;
#(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ADDR_W-1:0]          araddr,
    input  logic                       arvalid,
    output logic                       arready,
    output logic [DATA_W-1:0]          rdata,
    output logic [1:0]                 rresp,
    output logic                       rvalid,
    input  logic                       rready,
    input  logic [NUM_REGS*DATA_W-1:0] regs_flat
);

    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int WORD_W = ADDR_W - ADDR_LSB;

    rd_state_t         state;
    rd_state_t         state_next;
    logic              arready_next;
    logic              ar_hs;
    logic              in_range;
    logic [WORD_W-1:0] word;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] sel;
    logic              unused_ok;

    assign word     = araddr[ADDR_LSB +: WORD_W];
    assign idx      = word[IDX_W-1:0];
    assign in_range = ({1'b0, word} < (WORD_W+1)'(NUM_REGS));
    assign ar_hs    = arvalid & arready;
    assign rvalid   = (state == RD_DATA);

    assign unused_ok = ^{araddr[ADDR_LSB-1:0], word, in_range};

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == IDX_W'(i)) sel = regs_flat[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RD_IDLE: if (ar_hs)  state_next = RD_DATA;
            RD_DATA: if (rready) state_next = RD_IDLE;
            default:             state_next = RD_IDLE;
        endcase
        arready_next = (state_next == RD_IDLE);
    end

    // Read data is captured at the AR edge, so a concurrent write is not visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RD_IDLE;
            arready <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            state   <= state_next;
            arready <= arready_next;
            if (ar_hs) begin
`ifdef ACL2_AXIL_SLVERR_EN
                rdata <= in_range ? sel : '0;
                rresp <= in_range ? RESP_OKAY : RESP_SLVERR;
`else
                rdata <= sel;
                rresp <= RESP_OKAY;
`endif
            end
        end
    end

endmodule

// File: rtl/acl2_axil_slave_regs.sv
// AXI4-Lite slave register bank for the ACL2 PMOD core (write FSM + register array).
// Optional macro ACL2_AXIL_SLVERR_EN: out-of-range writes are dropped with SLVERR.
module acl2_axil_slave_regs
    import acl2_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_REGS           = 4
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]                    reg_wr_pulse
);

    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int STRB_W = DW / 8;
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int WORD_W = C_S_AXI_ADDR_WIDTH - ADDR_LSB;

    wr_state_t         wr_state;
    wr_state_t         wr_next;
    logic              aw_held;
    logic              w_held;
    logic              aw_held_next;
    logic              w_held_next;
    logic              awready_next;
    logic              wready_next;
    logic              aw_hs;
    logic              w_hs;
    logic              commit;
    logic [WORD_W-1:0] aw_word_q;
    logic [DW-1:0]     wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [WORD_W-1:0] c_word;
    logic [DW-1:0]     c_data;
    logic [STRB_W-1:0] c_strb;
    logic [IDX_W-1:0]  c_idx;
    logic              c_in_range;
    logic              wr_ok;
    logic [1:0]        bresp_q;
    logic [DW-1:0]     regs [NUM_REGS];
    logic              unused_ok;

    assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;

    // The commit may coincide with either handshake, so take whichever copy is current.
    assign c_word     = aw_held ? aw_word_q : S_AXI_AWADDR[ADDR_LSB +: WORD_W];
    assign c_data     = w_held ? wdata_q : S_AXI_WDATA;
    assign c_strb     = w_held ? wstrb_q : S_AXI_WSTRB;
    assign c_idx      = c_word[IDX_W-1:0];
    assign c_in_range = ({1'b0, c_word} < (WORD_W+1)'(NUM_REGS));
`ifdef ACL2_AXIL_SLVERR_EN
    assign wr_ok = c_in_range;
`else
    assign wr_ok = 1'b1;
`endif

    assign S_AXI_BVALID = (wr_state == WR_RESP);
    assign S_AXI_BRESP  = bresp_q;

    assign unused_ok = ^{S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_AWPROT, S_AXI_ARPROT,
                         c_word, c_in_range};

    always_comb begin
        wr_next      = wr_state;
        aw_held_next = aw_held;
        w_held_next  = w_held;
        commit       = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                if (aw_hs) aw_held_next = 1'b1;
                if (w_hs)  w_held_next  = 1'b1;
                if ((aw_held | aw_hs) && (w_held | w_hs)) begin
                    commit       = 1'b1;
                    wr_next      = WR_RESP;
                    aw_held_next = 1'b0;
                    w_held_next  = 1'b0;
                end
            end
            WR_RESP: if (S_AXI_BREADY) wr_next = WR_IDLE;
            default: wr_next = WR_IDLE;
        endcase
        awready_next = (wr_next == WR_IDLE) && !aw_held_next;
        wready_next  = (wr_next == WR_IDLE) && !w_held_next;
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_state      <= WR_IDLE;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            bresp_q       <= RESP_OKAY;
        end else begin
            wr_state      <= wr_next;
            aw_held       <= aw_held_next;
            w_held        <= w_held_next;
            S_AXI_AWREADY <= awready_next;
            S_AXI_WREADY  <= wready_next;
            if (commit) bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (aw_hs) aw_word_q <= S_AXI_AWADDR[ADDR_LSB +: WORD_W];
        if (w_hs) begin
            wdata_q <= S_AXI_WDATA;
            wstrb_q <= S_AXI_WSTRB;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            reg_wr_pulse <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_wr_pulse[i] <= commit && wr_ok && (c_idx == IDX_W'(i)) && (|c_strb);
                if (commit && wr_ok && (c_idx == IDX_W'(i))) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (c_strb[b]) regs[i][8*b +: 8] <= c_data[8*b +: 8];
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
        assign reg_q[g*DW +: DW] = regs[g];
    end

    acl2_axil_rd_chan #(
        .ADDR_W   (C_S_AXI_ADDR_WIDTH),
        .DATA_W   (DW),
        .NUM_REGS (NUM_REGS)
    ) u_rd_chan (
        .clk       (S_AXI_ACLK),
        .rst_n     (S_AXI_ARESETN),
        .araddr    (S_AXI_ARADDR),
        .arvalid   (S_AXI_ARVALID),
        .arready   (S_AXI_ARREADY),
        .rdata     (S_AXI_RDATA),
        .rresp     (S_AXI_RRESP),
        .rvalid    (S_AXI_RVALID),
        .rready    (S_AXI_RREADY),
        .regs_flat (reg_q)
    );

endmodule

// File: tb/tb_acl2_axil_slave_regs.sv
// Directed and randomized bench for acl2_axil_slave_regs against an array-based register model.
// Honours ACL2_AXIL_SLVERR_EN when computing expected responses.
module tb_acl2_axil_slave_regs;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [5:0]   awaddr;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [5:0]   araddr;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [127:0] reg_q;
    logic [3:0]   reg_wr_pulse;

    int total = 0;
    int bad   = 0;
    logic [31:0] model [4];

    always #5 clk = ~clk;

    acl2_axil_slave_regs dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .reg_q         (reg_q),
        .reg_wr_pulse  (reg_wr_pulse)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic timeout(input string tag);
        total++;
        bad++;
        $error("FAIL %s observed=timeout expected=handshake", tag);
    endtask

    // Word index the model targets; -1 marks an address that must not touch any register.
    function automatic int eff_idx(input logic [5:0] a);
        int w;
        w = int'(a) / 4;
`ifdef ACL2_AXIL_SLVERR_EN
        return (w < 4) ? w : -1;
`else
        return w % 4;
`endif
    endfunction

    task automatic model_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                               output logic [1:0] exp_resp, output logic [3:0] exp_pulse);
        int i;
        i = eff_idx(a);
        exp_pulse = 4'b0;
        if (i < 0) begin
            exp_resp = 2'b10;
        end else begin
            exp_resp = 2'b00;
            for (int b = 0; b < 4; b++) if (s[b]) model[i][8*b +: 8] = d[8*b +: 8];
            if (s != 4'b0) exp_pulse[i] = 1'b1;
        end
    endtask

    task automatic model_read(input logic [5:0] a, output logic [31:0] exp_data,
                              output logic [1:0] exp_resp);
        int i;
        i = eff_idx(a);
        exp_data = (i < 0) ? 32'h0 : model[i];
        exp_resp = (i < 0) ? 2'b10 : 2'b00;
    endtask

    task automatic hs_aw(input logic [5:0] a);
        int n = 0;
        awaddr = a; awprot = 3'($urandom); awvalid = 1'b1;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        if (!awready) timeout("aw_handshake");
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic hs_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        wdata = d; wstrb = s; wvalid = 1'b1;
        while (!wready && n < 20) begin @(negedge clk); n++; end
        if (!wready) timeout("w_handshake");
        @(negedge clk);
        wvalid = 1'b0;
    endtask

    task automatic hs_ar(input logic [5:0] a);
        int n = 0;
        araddr = a; arprot = 3'($urandom); arvalid = 1'b1;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        if (!arready) timeout("ar_handshake");
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic b_accept(output logic [1:0] resp);
        int n = 0;
        bready = 1'b1;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        if (!bvalid) timeout("b_handshake");
        resp = bresp;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic r_accept(output logic [31:0] d, output logic [1:0] resp);
        int n = 0;
        rready = 1'b1;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        if (!rvalid) timeout("r_handshake");
        d = rdata; resp = rresp;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output logic [3:0] pulse);
        int   n = 0;
        logic aw_now, w_now;
        awaddr = a; awprot = 3'($urandom); wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        while ((awvalid || wvalid) && n < 20) begin
            aw_now = awvalid && awready;
            w_now  = wvalid && wready;
            @(negedge clk);
            n++;
            if (aw_now) awvalid = 1'b0;
            if (w_now)  wvalid  = 1'b0;
        end
        if (awvalid || wvalid) begin
            timeout("write_addr_data");
            awvalid = 1'b0; wvalid = 1'b0;
        end
        pulse = reg_wr_pulse;
        b_accept(resp);
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
        hs_ar(a);
        r_accept(d, resp);
    endtask

    initial begin
        logic [1:0]  resp, exp_resp;
        logic [3:0]  pulse, exp_pulse;
        logic [31:0] d, exp_d, held;
        logic [5:0]  a;
        logic [3:0]  s;

        rst_n = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = 32'h0;
        repeat (3) @(negedge clk);

        check("rst_awready", 32'(awready), 32'h0);
        check("rst_wready",  32'(wready),  32'h0);
        check("rst_arready", 32'(arready), 32'h0);
        check("rst_bvalid",  32'(bvalid),  32'h0);
        check("rst_rvalid",  32'(rvalid),  32'h0);
        check("rst_rdata",   rdata,        32'h0);
        check("rst_resp",    32'({bresp, rresp}), 32'h0);
        check("rst_pulse",   32'(reg_wr_pulse), 32'h0);
        for (int i = 0; i < 4; i++) check("rst_reg_q", reg_q[32*i +: 32], 32'h0);

        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", 32'({awready, wready, arready}), 32'h7);

        // basic write and read-back of every register
        for (int i = 0; i < 4; i++) begin
            axi_write(6'(4*i), 32'(i + 1), 4'hF, resp, pulse);
            model_write(6'(4*i), 32'(i + 1), 4'hF, exp_resp, exp_pulse);
            check("t1_bresp", 32'(resp), 32'(exp_resp));
            check("t1_pulse", 32'(pulse), 32'(exp_pulse));
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(6'(4*i), d, resp);
            check("t1_rdata", d, 32'(i + 1));
            check("t1_rresp", 32'(resp), 32'h0);
        end

        // AW three cycles ahead of W
        hs_aw(6'h4);
        check("t2a_awready_drop", 32'(awready), 32'h0);
        repeat (3) begin
            check("t2a_bvalid_early", 32'(bvalid), 32'h0);
            @(negedge clk);
        end
        hs_w(32'hCAFE0001, 4'hF);
        check("t2a_bvalid_rise", 32'(bvalid), 32'h1);
        b_accept(resp);
        model_write(6'h4, 32'hCAFE0001, 4'hF, exp_resp, exp_pulse);
        check("t2a_bresp", 32'(resp), 32'(exp_resp));

        // W three cycles ahead of AW
        hs_w(32'hBEEF0002, 4'hF);
        check("t2b_wready_drop", 32'(wready), 32'h0);
        repeat (3) begin
            check("t2b_bvalid_early", 32'(bvalid), 32'h0);
            @(negedge clk);
        end
        hs_aw(6'h8);
        check("t2b_bvalid_rise", 32'(bvalid), 32'h1);
        b_accept(resp);
        model_write(6'h8, 32'hBEEF0002, 4'hF, exp_resp, exp_pulse);
        axi_read(6'h8, d, resp);
        check("t2b_rdata", d, model[2]);
        axi_read(6'h4, d, resp);
        check("t2a_rdata", d, model[1]);

        // B backpressure
        hs_aw(6'hC);
        hs_w(32'h0BADF00D, 4'hF);
        model_write(6'hC, 32'h0BADF00D, 4'hF, exp_resp, exp_pulse);
        repeat (5) begin
            check("t3_bvalid_held", 32'(bvalid), 32'h1);
            check("t3_ready_low", 32'({awready, wready}), 32'h0);
            @(negedge clk);
        end
        b_accept(resp);
        check("t3_bresp", 32'(resp), 32'h0);
        check("t3_ready_back", 32'({awready, wready, bvalid}), 32'h6);
        axi_write(6'h0, 32'h12345678, 4'hF, resp, pulse);
        model_write(6'h0, 32'h12345678, 4'hF, exp_resp, exp_pulse);
        check("t3_next_bresp", 32'(resp), 32'(exp_resp));
        check("t3_reg3", reg_q[96 +: 32], model[3]);

        // partial byte strobe
        axi_write(6'h4, 32'hAABBCCDD, 4'hF, resp, pulse);
        model_write(6'h4, 32'hAABBCCDD, 4'hF, exp_resp, exp_pulse);
        axi_write(6'h4, 32'h11223344, 4'b0010, resp, pulse);
        model_write(6'h4, 32'h11223344, 4'b0010, exp_resp, exp_pulse);
        check("t4_pulse", 32'(pulse), 32'h2);
        check("t4_pulse_end", 32'(reg_wr_pulse), 32'h0);
        check("t4_reg_q", reg_q[32 +: 32], 32'hAABB33DD);
        axi_read(6'h4, d, resp);
        check("t4_rdata", d, model[1]);

        // R backpressure with a write to the same register during the stall
        held = model[2];
        hs_ar(6'h8);
        check("t5_rvalid", 32'(rvalid), 32'h1);
        check("t5_rdata_first", rdata, held);
        axi_write(6'h8, ~held, 4'hF, resp, pulse);
        model_write(6'h8, ~held, 4'hF, exp_resp, exp_pulse);
        repeat (4) begin
            check("t5_rvalid_held", 32'(rvalid), 32'h1);
            check("t5_rdata_held", rdata, held);
            @(negedge clk);
        end
        r_accept(d, resp);
        check("t5_rdata_final", d, held);
        check("t5_ar_back", 32'({arready, rvalid}), 32'h2);
        check("t5_reg_new", reg_q[64 +: 32], model[2]);

        // reset between AW and W handshakes
        hs_aw(6'h8);
        rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) model[i] = 32'h0;
        check("t6_bvalid", 32'(bvalid), 32'h0);
        for (int i = 0; i < 4; i++) check("t6_reg_q", reg_q[32*i +: 32], 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_bvalid_rel", 32'(bvalid), 32'h0);
        axi_write(6'h8, 32'h5A, 4'hF, resp, pulse);
        model_write(6'h8, 32'h5A, 4'hF, exp_resp, exp_pulse);
        check("t6_bresp", 32'(resp), 32'h0);
        axi_read(6'h8, d, resp);
        check("t6_rdata", d, 32'h5A);
        axi_read(6'h4, d, resp);
        check("t6_reg1_zero", d, 32'h0);

        // address beyond the implemented registers
        axi_write(6'h0, 32'h0000C0DE, 4'hF, resp, pulse);
        model_write(6'h0, 32'h0000C0DE, 4'hF, exp_resp, exp_pulse);
        axi_read(6'h10, d, resp);
        model_read(6'h10, exp_d, exp_resp);
        check("t7_rdata", d, exp_d);
        check("t7_rresp", 32'(resp), 32'(exp_resp));

        // randomized mix of writes and reads
        for (int k = 0; k < 40; k++) begin
            a = 6'($urandom);
            d = $urandom;
            s = 4'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                axi_write(a, d, s, resp, pulse);
                model_write(a, d, s, exp_resp, exp_pulse);
                check("rnd_bresp", 32'(resp), 32'(exp_resp));
                check("rnd_pulse", 32'(pulse), 32'(exp_pulse));
            end else begin
                axi_read(a, d, resp);
                model_read(a, exp_d, exp_resp);
                check("rnd_rdata", d, exp_d);
                check("rnd_rresp", 32'(resp), 32'(exp_resp));
            end
        end
        for (int i = 0; i < 4; i++) check("final_reg_q", reg_q[32*i +: 32], model[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
